bram_burst_loader: RTL
======================

# bram_burst_loader

Upstream write-port driver for the `BRAMLike` block RAM. It accepts a burst command (base address plus word count) and a valid/ready stream of data words. It converts them into registered `wen`/`waddr`/`din` writes at consecutive addresses, wrapping modulo memory depth. It sits between the host/DMA word stream and each core's BRAM, and loads instruction and register-file images before execution starts.

## Interface
Parameters:
- `DATA_WIDTH`, 16, stream word width; equals the BRAM write width.
- `ADDRESS_WIDTH`, 11, BRAM address width; depth is 2^ADDRESS_WIDTH.

Ports:
- `clock`  in  1  sole clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `cmd_valid`  in  1  burst command valid.
- `cmd_ready`  out  1  high only in IDLE.
- `cmd_base`  in  ADDRESS_WIDTH  first write address.
- `cmd_count`  in  ADDRESS_WIDTH+1  words in the burst, 0..2^ADDRESS_WIDTH.
- `in_valid`  in  1  data word valid.
- `in_ready`  out  1  loader accepts a word.
- `in_data`  in  DATA_WIDTH  data word.
- `abort`  in  1  terminate the current burst.
- `wen`  out  1  BRAM write enable, registered.
- `waddr`  out  ADDRESS_WIDTH  BRAM write address, registered.
- `din`  out  DATA_WIDTH  BRAM write data, registered.
- `busy`  out  1  state is not IDLE.
- `done`  out  1  one-cycle pulse at burst end.
- `aborted`  out  1  valid with `done`; burst was cut short.

## Operation
- FSM states: IDLE, LOAD, DONE.
- IDLE:
  - `cmd_ready`=1.
  - On `cmd_valid` with `cmd_count`≠0: latch base and count, clear the word index, go to LOAD.
  - On `cmd_valid` with `cmd_count`=0: go to DONE, issue no writes, `aborted`=0.
- LOAD:
  - `in_ready` = ~`abort`.
  - On each handshake (`in_valid`&`in_ready`), the next cycle has `wen`=1, `waddr`=(base+index) mod 2^ADDRESS_WIDTH, `din`=`in_data`; index then increments.
  - A handshake on the last word goes to DONE with `aborted`=0.
  - `abort`=1 in LOAD goes to DONE with `aborted`=1; the word presented that cycle is not accepted.
- DONE:
  - `done`=1 for exactly one cycle, then IDLE.
  - `in_ready`=0 and `cmd_ready`=0 in DONE.
- `abort` is ignored in IDLE and DONE.
- Addressing:
  - The address adder is ADDRESS_WIDTH bits and discards the carry, so base 2^ADDRESS_WIDTH−1 is followed by address 0.
  - A full-depth burst (count = 2^ADDRESS_WIDTH) writes every address exactly once.
- `wen` is 0 in every cycle not immediately following a handshake.

## Timing
- Reset: state IDLE, `wen`/`waddr`/`din`/`busy`/`done`/`aborted`=0, index 0.
- A reset asserted mid-burst drops any pending write and produces no `done`.
- Command latency: `cmd_ready` handshake at cycle t gives `in_ready`=1 at t+1. For count 0, `done` is at t+1.
- Write latency: a handshake at cycle t gives `wen`=1 at t+1.
- Throughput: one word per cycle sustained.
- Last-word handshake at t: the last `wen` and `done` both occur at t+1, and `cmd_ready` returns at t+2.
- `busy` is high from t+1 of the command handshake through the `done` cycle.
- `cmd_ready` and `in_ready` depend combinationally only on state and `abort`, never on `*_valid`.

## Configuration
- `BRAM_LOADER_CHECKSUM_EN` defined:
  - Adds output `checksum` [DATA_WIDTH], the sum of all words accepted in the current burst, modulo 2^DATA_WIDTH.
  - The sum clears on command accept and is held stable from the `done` cycle until the next command accept.
  - Reset value is 0.
- Not defined: no `checksum` port and no accumulator logic; all other behaviour is identical.

## Structure
- Shared package `manticore_bram_pkg`:
  - FSM state enum (IDLE, LOAD, DONE).
  - Default `DATA_WIDTH`/`ADDRESS_WIDTH` constants.
  - Count width as ADDRESS_WIDTH+1.
- Sub-module `bram_loader_checksum`: the accumulator, instantiated only under `BRAM_LOADER_CHECKSUM_EN`. All other logic stays in the top module.

## Test plan
- Base 0x010, count 4, words 0xA000..0xA003 streamed back to back:
  - `wen` is high at 4 consecutive cycles, addresses 0x010..0x013.
  - `done`=1 with `aborted`=0, coincident with the 4th write.
  - Checksum 0x8006 when enabled.
- Base 0x7FE, count 4 → writes to 0x7FE, 0x7FF, 0x000, 0x001.
- Count 0 → no `wen`; `done` one cycle after accept; `cmd_ready` back two cycles after accept.
- Count 8 with `in_valid` toggling every other cycle → 8 writes, each one cycle after its handshake, with no gaps or duplicate addresses.
- `abort` asserted after 3 of 8 accepted, with `in_valid`=1 that cycle → exactly 3 writes, that word not accepted, `done`=1 and `aborted`=1.
- `reset_n` pulsed low while in LOAD → all outputs 0 asynchronously; `cmd_ready`=1 after release; no `done` for the interrupted burst.

Source files
------------

// File: rtl/manticore_bram_pkg.sv
// Shared types and default geometry for the BRAM loader family.
package manticore_bram_pkg;

    localparam int DEFAULT_DATA_WIDTH    = 16;
    localparam int DEFAULT_ADDRESS_WIDTH = 11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } loader_state_t;

    // A burst may cover the whole memory, so the count needs one extra bit.
    function automatic int count_width(input int address_width);
        return address_width + 1;
    endfunction

endpackage

// File: rtl/bram_loader_checksum.sv
// Running modulo-2^DATA_WIDTH sum of words accepted in the current burst.
module bram_loader_checksum #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  clear,
    input  logic                  add_en,
    input  logic [DATA_WIDTH-1:0] add_data,
    output logic [DATA_WIDTH-1:0] sum
);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sum <= '0;
        end else if (clear) begin
            sum <= '0;
        end else if (add_en) begin
            sum <= sum + add_data;
        end
    end

endmodule

// File: rtl/bram_burst_loader.sv
// Burst write-port driver for BRAMLike: command + word stream -> registered wen/waddr/din.
// Optional running checksum output when BRAM_LOADER_CHECKSUM_EN is defined.
module bram_burst_loader
    import manticore_bram_pkg::*;
#(
    parameter int DATA_WIDTH    = DEFAULT_DATA_WIDTH,
    parameter int ADDRESS_WIDTH = DEFAULT_ADDRESS_WIDTH
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [ADDRESS_WIDTH-1:0] cmd_base,
    input  logic [ADDRESS_WIDTH:0]   cmd_count,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_WIDTH-1:0]    in_data,
    input  logic                     abort,
    output logic                     wen,
    output logic [ADDRESS_WIDTH-1:0] waddr,
    output logic [DATA_WIDTH-1:0]    din,
    output logic                     busy,
    output logic                     done,
    output logic                     aborted
`ifdef BRAM_LOADER_CHECKSUM_EN
    ,
    output logic [DATA_WIDTH-1:0]    checksum
`endif
);

    localparam int COUNT_WIDTH = count_width(ADDRESS_WIDTH);

    loader_state_t state, state_next;

    logic [ADDRESS_WIDTH-1:0] base_q;
    logic [COUNT_WIDTH-1:0]   count_q;
    logic [COUNT_WIDTH-1:0]   index_q;
    logic                     abort_flag;
    logic                     cmd_fire;
    logic                     in_fire;
    logic                     last_word;

    assign cmd_fire  = cmd_valid & cmd_ready;
    assign in_fire   = in_valid & in_ready;
    assign last_word = (index_q + COUNT_WIDTH'(1)) == count_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Handshake signals depend only on state and abort, never on the valids.
    always_comb begin
        state_next = state;
        cmd_ready  = 1'b0;
        in_ready   = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
                if (cmd_valid) begin
                    state_next = (cmd_count == '0) ? DONE : LOAD;
                end
            end
            LOAD: begin
                in_ready = ~abort;
                if (abort || (in_valid && last_word)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign aborted = done & abort_flag;

    // Write stage: one accepted word becomes one BRAM write on the next cycle.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wen        <= 1'b0;
            waddr      <= '0;
            din        <= '0;
            base_q     <= '0;
            count_q    <= '0;
            index_q    <= '0;
            abort_flag <= 1'b0;
        end else begin
            wen <= in_fire;
            if (in_fire) begin
                waddr   <= base_q + index_q[ADDRESS_WIDTH-1:0];
                din     <= in_data;
                index_q <= index_q + COUNT_WIDTH'(1);
            end
            if (cmd_fire) begin
                base_q     <= cmd_base;
                count_q    <= cmd_count;
                index_q    <= '0;
                abort_flag <= 1'b0;
            end else if (state == LOAD && abort) begin
                abort_flag <= 1'b1;
            end
        end
    end

`ifdef BRAM_LOADER_CHECKSUM_EN
    bram_loader_checksum #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_checksum (
        .clock    (clock),
        .reset_n  (reset_n),
        .clear    (cmd_fire),
        .add_en   (in_fire),
        .add_data (in_data),
        .sum      (checksum)
    );
`endif

endmodule
